// File: rtl/imu_fusion_pkg.sv
// -----------------------------------------------------------------------------
// imu_fusion_pkg
// Shared types and helpers for the time-multiplexed IMU fusion pipeline.
//   fsmState_t    : sequencer states IDLE -> AVG -> FUSE -> DONE
//   INT_GUARD_W   : guard bits added to DATA_W for the fusion arithmetic
//   sumWidth()    : running-sum width of the moving average (DATA_W+AVG_LOG2)
//   intWidth()    : internal fusion width (DATA_W+INT_GUARD_W)
//   sat_to_width(): clamp a signed value into a signed field of given width
// -----------------------------------------------------------------------------
package imu_fusion_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AVG  = 2'd1,
        FUSE = 2'd2,
        DONE = 2'd3
    } fsmState_t;

    localparam int INT_GUARD_W = 2;

    // A sum of 2^avgLog2 samples of dataW bits never needs more than this.
    function automatic int sumWidth(input int dataW, input int avgLog2);
        return dataW + avgLog2;
    endfunction

    function automatic int intWidth(input int dataW);
        return dataW + INT_GUARD_W;
    endfunction

    function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] value,
                                                         input int width);
        logic signed [31:0] hiLim;
        logic signed [31:0] loLim;
        hiLim = (32'sd1 <<< (width - 1)) - 32'sd1;
        loLim = -(32'sd1 <<< (width - 1));
        if (value > hiLim)
            return hiLim;
        else if (value < loLim)
            return loLim;
        else
            return value;
    endfunction

endpackage

// File: rtl/imu_fusion_pipeline_if.sv
// -----------------------------------------------------------------------------
// imu_fusion_pipeline_if
// Sample-in / angle-out bundle of the IMU fusion pipeline.
//   DataValid, AccelIn, GyroIn     : producer -> pipeline (channel 0 in LSBs)
//   InputReady                     : pipeline can take a new strobe
//   FilteredAccel, AngleOut        : per-channel results, channel 0 in LSBs
//   AngleValid                     : one-cycle pulse when results update
//   Overrun                        : sticky, a strobe arrived while busy
// master = sample producer / result consumer, slave = the pipeline.
// -----------------------------------------------------------------------------
interface imu_fusion_pipeline_if #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 10
);
    logic                         DataValid;
    logic [CHANNELS*DATA_W-1:0]   AccelIn;
    logic [CHANNELS*DATA_W-1:0]   GyroIn;
    logic                         InputReady;
    logic [CHANNELS*DATA_W-1:0]   FilteredAccel;
    logic [CHANNELS*DATA_W-1:0]   AngleOut;
    logic                         AngleValid;
    logic                         Overrun;

    modport master (
        output DataValid, AccelIn, GyroIn,
        input  InputReady, FilteredAccel, AngleOut, AngleValid, Overrun
    );

    modport slave (
        input  DataValid, AccelIn, GyroIn,
        output InputReady, FilteredAccel, AngleOut, AngleValid, Overrun
    );
endinterface

// File: rtl/imu_moving_average.sv
// -----------------------------------------------------------------------------
// imu_moving_average
// Channel-multiplexed ring-buffer moving average, depth 2^AVG_LOG2.
// One channel is updated per cycle; all channels share one write pointer,
// which moves on only after the last channel of a sample has been written.
//   clk, rst  : clock, asynchronous active-high reset (history/sums/ptr = 0)
//   update    : write sampleIn into channel chSel this cycle
//   advance   : step the shared write pointer (wraps modulo depth)
//   chSel     : channel being updated
//   sampleIn  : new signed sample
//   avgOut    : floor((sum + new - oldest) / depth), combinational
// -----------------------------------------------------------------------------
module imu_moving_average
    import imu_fusion_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 10,
    parameter int AVG_LOG2 = 3,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     update,
    input  logic                     advance,
    input  logic [CH_W-1:0]          chSel,
    input  logic signed [DATA_W-1:0] sampleIn,
    output logic signed [DATA_W-1:0] avgOut
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = sumWidth(DATA_W, AVG_LOG2);

    logic signed [DATA_W-1:0] hist [CHANNELS][DEPTH];
    logic signed [SUM_W-1:0]  runSum [CHANNELS];
    logic [AVG_LOG2-1:0]      wrPtr;
    logic signed [SUM_W-1:0]  newSum;

    // The updated window sum always fits SUM_W, so wrap-around in the
    // intermediate add/subtract cancels out.
    assign newSum = runSum[chSel] + SUM_W'(sampleIn) - SUM_W'(hist[chSel][wrPtr]);
    assign avgOut = DATA_W'(newSum >>> AVG_LOG2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                runSum[c] <= '0;
                for (int d = 0; d < DEPTH; d++)
                    hist[c][d] <= '0;
            end
        end else begin
            if (update) begin
                runSum[chSel]      <= newSum;
                hist[chSel][wrPtr] <= sampleIn;
            end
            if (advance)
                wrPtr <= wrPtr + AVG_LOG2'(1);
        end
    end
endmodule

// File: rtl/imu_fusion_pipeline.sv
// -----------------------------------------------------------------------------
// imu_fusion_pipeline
// Time-multiplexed moving-average + complementary filter for CHANNELS
// accel/gyro axis pairs. A strobe in IDLE latches all channels; AVG then
// filters one accel channel per cycle, FUSE merges one channel per cycle,
// DONE pulses AngleValid. Latency 2*CHANNELS+1, one sample per
// 2*CHANNELS+2 cycles.
//   Clock, Reset : clock, asynchronous active-high reset
//   imu          : imu_fusion_pipeline_if.slave (see interface header)
// Optional build macro IMU_ACCEL_SEED_EN: the first FUSE pass after reset
// loads each angle straight from its filtered accel value.
// -----------------------------------------------------------------------------
module imu_fusion_pipeline
    import imu_fusion_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int DATA_W      = 10,
    parameter int AVG_LOG2    = 3,
    parameter int GYRO_SHIFT  = 6,
    parameter int ALPHA_SHIFT = 4
)(
    input  logic                  Clock,
    input  logic                  Reset,
    imu_fusion_pipeline_if.slave  imu
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int INT_W = intWidth(DATA_W);

    fsmState_t state, nextState;
    logic      readyComb, validComb;

    logic [CH_W-1:0]          chIdx;
    logic                     lastCh;
    logic signed [DATA_W-1:0] accelLat [CHANNELS];
    logic signed [DATA_W-1:0] gyroLat  [CHANNELS];
    logic signed [DATA_W-1:0] facc     [CHANNELS];
    logic signed [DATA_W-1:0] angle    [CHANNELS];
    logic                     overrun;
    logic signed [DATA_W-1:0] avgOut;

    logic signed [INT_W-1:0]  gyroTerm, predicted, corr, fused;
    logic signed [DATA_W-1:0] fusedSat, angleNext;
    logic [CHANNELS*DATA_W-1:0] faccPacked, anglePacked;

`ifdef IMU_ACCEL_SEED_EN
    logic seeded;
`endif

    assign lastCh = (chIdx == CH_W'(CHANNELS - 1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        readyComb = 1'b0;
        validComb = 1'b0;
        case (state)
            IDLE: begin
                readyComb = 1'b1;
                if (imu.DataValid)
                    nextState = AVG;
            end
            AVG:  if (lastCh) nextState = FUSE;
            FUSE: if (lastCh) nextState = DONE;
            DONE: begin
                validComb = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    imu_moving_average #(
        .CHANNELS (CHANNELS),
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2),
        .CH_W     (CH_W)
    ) uAvg (
        .clk      (Clock),
        .rst      (Reset),
        .update   (state == AVG),
        .advance  ((state == AVG) && lastCh),
        .chSel    (chIdx),
        .sampleIn (accelLat[chIdx]),
        .avgOut   (avgOut)
    );

    // Complementary filter for the channel selected by chIdx. Guard bits
    // keep angle+rate and the correction difference from wrapping before
    // the final clamp.
    always_comb begin
        gyroTerm  = INT_W'(gyroLat[chIdx]) >>> GYRO_SHIFT;
        predicted = INT_W'(angle[chIdx]) + gyroTerm;
        corr      = (predicted - INT_W'(facc[chIdx])) >>> ALPHA_SHIFT;
        fused     = predicted - corr;
        fusedSat  = DATA_W'(sat_to_width(32'(fused), DATA_W));
`ifdef IMU_ACCEL_SEED_EN
        angleNext = seeded ? fusedSat : facc[chIdx];
`else
        angleNext = fusedSat;
`endif
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            chIdx   <= '0;
            overrun <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                accelLat[c] <= '0;
                gyroLat[c]  <= '0;
                facc[c]     <= '0;
                angle[c]    <= '0;
            end
`ifdef IMU_ACCEL_SEED_EN
            seeded <= 1'b0;
`endif
        end else begin
            // Strobes outside IDLE (DONE included) are dropped but remembered.
            if (imu.DataValid && (state != IDLE))
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (imu.DataValid) begin
                        chIdx <= '0;
                        for (int c = 0; c < CHANNELS; c++) begin
                            accelLat[c] <= imu.AccelIn[c*DATA_W +: DATA_W];
                            gyroLat[c]  <= imu.GyroIn[c*DATA_W +: DATA_W];
                        end
                    end
                end
                AVG: begin
                    facc[chIdx] <= avgOut;
                    chIdx       <= lastCh ? '0 : chIdx + CH_W'(1);
                end
                FUSE: begin
                    angle[chIdx] <= angleNext;
                    chIdx        <= lastCh ? '0 : chIdx + CH_W'(1);
                end
                DONE: begin
`ifdef IMU_ACCEL_SEED_EN
                    seeded <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        faccPacked  = '0;
        anglePacked = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            faccPacked[c*DATA_W +: DATA_W]  = facc[c];
            anglePacked[c*DATA_W +: DATA_W] = angle[c];
        end
    end

    assign imu.InputReady    = readyComb;
    assign imu.AngleValid    = validComb;
    assign imu.Overrun       = overrun;
    assign imu.FilteredAccel = faccPacked;
    assign imu.AngleOut      = anglePacked;
endmodule

// File: tb/tb_imu_fusion_pipeline.sv
// -----------------------------------------------------------------------------
// tb_imu_fusion_pipeline
// Self-checking bench for imu_fusion_pipeline (CHANNELS=2, DATA_W=10,
// AVG_LOG2=3, GYRO_SHIFT=6, ALPHA_SHIFT=4). Honours IMU_ACCEL_SEED_EN.
// The reference model keeps the last eight accel samples per channel and
// recomputes the whole window average and the filter with integer maths.
// -----------------------------------------------------------------------------
module tb_imu_fusion_pipeline;
    localparam int CH = 2;
    localparam int DW = 10;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    imu_fusion_pipeline_if #(.CHANNELS(CH), .DATA_W(DW)) bus ();

    imu_fusion_pipeline #(
        .CHANNELS(CH), .DATA_W(DW), .AVG_LOG2(3), .GYRO_SHIFT(6), .ALPHA_SHIFT(4)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .imu   (bus)
    );

    always #5 Clock = ~Clock;

    // ---------------- reference model ----------------
    int histM [CH][8];
    int wpM;
    int angleM [CH];
    bit seededM;

    function automatic int floorDiv(input int v, input int d);
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    function automatic int clampDw(input int v);
        if (v > 511) return 511;
        if (v < -512) return -512;
        return v;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < CH; c++) begin
            for (int d = 0; d < 8; d++) histM[c][d] = 0;
            angleM[c] = 0;
        end
        wpM = 0;
        seededM = 0;
    endtask

    task automatic modelStep(input int a0, input int a1, input int g0, input int g1,
                             output int ef0, output int ef1, output int ea0, output int ea1);
        int acc [CH];
        int gyr [CH];
        int fm  [CH];
        acc[0] = a0; acc[1] = a1; gyr[0] = g0; gyr[1] = g1;
        for (int c = 0; c < CH; c++) begin
            int total;
            int p;
            histM[c][wpM] = acc[c];
            total = 0;
            for (int d = 0; d < 8; d++) total += histM[c][d];
            fm[c] = floorDiv(total, 8);
            p = angleM[c] + floorDiv(gyr[c], 64);
`ifdef IMU_ACCEL_SEED_EN
            if (!seededM) angleM[c] = fm[c];
            else          angleM[c] = clampDw(p - floorDiv(p - fm[c], 16));
`else
            angleM[c] = clampDw(p - floorDiv(p - fm[c], 16));
`endif
        end
        wpM = (wpM + 1) % 8;
        seededM = 1;
        ef0 = fm[0]; ef1 = fm[1]; ea0 = angleM[0]; ea1 = angleM[1];
    endtask

    function automatic int outF(input int c);
        logic [CH*DW-1:0] v;
        logic signed [DW-1:0] s;
        v = bus.FilteredAccel;
        s = v[c*DW +: DW];
        return int'(s);
    endfunction

    function automatic int outA(input int c);
        logic [CH*DW-1:0] v;
        logic signed [DW-1:0] s;
        v = bus.AngleOut;
        s = v[c*DW +: DW];
        return int'(s);
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic doReset();
        @(negedge Clock);
        Reset = 1'b1;
        bus.DataValid = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        modelReset();
    endtask

    task automatic driveData(input int a0, input int a1, input int g0, input int g1);
        bus.AccelIn = {DW'(a1), DW'(a0)};
        bus.GyroIn  = {DW'(g1), DW'(g0)};
    endtask

    // Sends one sample when ready and returns outputs at AngleValid; lat=-1 on timeout.
    task automatic runSample(input int a0, input int a1, input int g0, input int g1,
                             output int f0, output int f1, output int an0, output int an1,
                             output int lat);
        lat = -1; f0 = 0; f1 = 0; an0 = 0; an1 = 0;
        for (int i = 0; i < 20 && !bus.InputReady; i++) @(negedge Clock);
        if (!bus.InputReady) return;
        driveData(a0, a1, g0, g1);
        bus.DataValid = 1'b1;
        @(posedge Clock);
        #1 bus.DataValid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge Clock);
            if (bus.AngleValid) begin
                lat = n;
                f0 = outF(0); f1 = outF(1); an0 = outA(0); an1 = outA(1);
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        doReset();
        checks++; if (bus.InputReady !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.InputReady); end
        checks++; if (bus.AngleValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.AngleValid); end
        checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", bus.Overrun); end
        checks++; if (bus.FilteredAccel !== '0) begin errors++; $display("FAIL reset_facc got=%h exp=0", bus.FilteredAccel); end
        checks++; if (bus.AngleOut !== '0) begin errors++; $display("FAIL reset_angle got=%h exp=0", bus.AngleOut); end
    endtask

    task automatic test_ramp();
        int f0, f1, a0, a1, lat, ef0, ef1, ea0, ea1, req;
        doReset();
        for (int i = 0; i < 9; i++) begin
            runSample(80, 80, 0, 0, f0, f1, a0, a1, lat);
            modelStep(80, 80, 0, 0, ef0, ef1, ea0, ea1);
            req = (i < 8) ? 10 * (i + 1) : 80;
            checks++; if (lat !== 5) begin errors++; $display("FAIL ramp_latency[%0d] got=%0d exp=5", i, lat); end
            checks++; if (f0 !== req) begin errors++; $display("FAIL ramp_facc0[%0d] got=%0d exp=%0d", i, f0, req); end
            checks++; if (f1 !== req) begin errors++; $display("FAIL ramp_facc1[%0d] got=%0d exp=%0d", i, f1, req); end
            checks++; if (a0 !== ea0) begin errors++; $display("FAIL ramp_angle0[%0d] got=%0d exp=%0d", i, a0, ea0); end
        end
    endtask

    task automatic test_latency();
        int ef0, ef1, ea0, ea1;
        for (int i = 0; i < 20 && !bus.InputReady; i++) @(negedge Clock);
        driveData(40, -40, 128, -128);
        bus.DataValid = 1'b1;
        @(posedge Clock);
        #1 bus.DataValid = 1'b0;
        modelStep(40, -40, 128, -128, ef0, ef1, ea0, ea1);
        for (int n = 1; n <= 7; n++) begin
            @(negedge Clock);
            checks++; if (bus.InputReady !== (n >= 6)) begin errors++; $display("FAIL lat_ready[c%0d] got=%b exp=%b", n, bus.InputReady, (n >= 6)); end
            checks++; if (bus.AngleValid !== (n == 5)) begin errors++; $display("FAIL lat_valid[c%0d] got=%b exp=%b", n, bus.AngleValid, (n == 5)); end
            if (n == 5) begin
                checks++; if (outF(1) !== ef1) begin errors++; $display("FAIL lat_facc1 got=%0d exp=%0d", outF(1), ef1); end
                checks++; if (outA(1) !== ea1) begin errors++; $display("FAIL lat_angle1 got=%0d exp=%0d", outA(1), ea1); end
            end
        end
    endtask

    task automatic test_overrun();
        int f0, f1, a0, a1, lat, ef0, ef1, ea0, ea1, pulses;
        doReset();
        driveData(200, -160, 64, -64);
        bus.DataValid = 1'b1;
        @(posedge Clock);
        #1 bus.DataValid = 1'b0;
        modelStep(200, -160, 64, -64, ef0, ef1, ea0, ea1);
        @(posedge Clock);
        #1 driveData(-300, 300, 500, 500);
        bus.DataValid = 1'b1;
        @(posedge Clock);
        #1 bus.DataValid = 1'b0;
        lat = -1;
        for (int n = 3; n <= 20; n++) begin
            @(negedge Clock);
            if (bus.AngleValid) begin lat = n; break; end
        end
        checks++; if (lat !== 5) begin errors++; $display("FAIL ovr_latency got=%0d exp=5", lat); end
        checks++; if (bus.Overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", bus.Overrun); end
        checks++; if (outF(0) !== ef0) begin errors++; $display("FAIL ovr_facc0 got=%0d exp=%0d", outF(0), ef0); end
        checks++; if (outF(1) !== ef1) begin errors++; $display("FAIL ovr_facc1 got=%0d exp=%0d", outF(1), ef1); end
        checks++; if (outA(0) !== ea0) begin errors++; $display("FAIL ovr_angle0 got=%0d exp=%0d", outA(0), ea0); end
        checks++; if (outA(1) !== ea1) begin errors++; $display("FAIL ovr_angle1 got=%0d exp=%0d", outA(1), ea1); end
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge Clock);
            if (bus.AngleValid) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL ovr_extra_pulses got=%0d exp=0", pulses); end
        runSample(120, 8, 0, 0, f0, f1, a0, a1, lat);
        modelStep(120, 8, 0, 0, ef0, ef1, ea0, ea1);
        checks++; if (lat !== 5) begin errors++; $display("FAIL ovr_next_latency got=%0d exp=5", lat); end
        checks++; if (f0 !== ef0) begin errors++; $display("FAIL ovr_next_facc0 got=%0d exp=%0d", f0, ef0); end
        checks++; if (a1 !== ea1) begin errors++; $display("FAIL ovr_next_angle1 got=%0d exp=%0d", a1, ea1); end
        checks++; if (bus.Overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", bus.Overrun); end
    endtask

    task automatic test_negative();
        int f0, f1, a0, a1, lat, ef0, ef1, ea0, ea1, reqA;
        doReset();
        runSample(-256, -256, 0, 0, f0, f1, a0, a1, lat);
        modelStep(-256, -256, 0, 0, ef0, ef1, ea0, ea1);
`ifdef IMU_ACCEL_SEED_EN
        reqA = -32;
`else
        reqA = -2;
`endif
        checks++; if (lat !== 5) begin errors++; $display("FAIL neg_latency got=%0d exp=5", lat); end
        checks++; if (f0 !== -32) begin errors++; $display("FAIL neg_facc0 got=%0d exp=-32", f0); end
        checks++; if (f1 !== ef1) begin errors++; $display("FAIL neg_facc1 got=%0d exp=%0d", f1, ef1); end
        checks++; if (a0 !== reqA) begin errors++; $display("FAIL neg_angle0 got=%0d exp=%0d", a0, reqA); end
        checks++; if (a1 !== ea1) begin errors++; $display("FAIL neg_angle1 got=%0d exp=%0d", a1, ea1); end
    endtask

    task automatic test_saturation();
        int f0, f1, a0, a1, lat, ef0, ef1, ea0, ea1, bad, negs;
        doReset();
        bad = 0; negs = 0;
        for (int i = 0; i < 200; i++) begin
            runSample(511, 511, 511, 511, f0, f1, a0, a1, lat);
            modelStep(511, 511, 511, 511, ef0, ef1, ea0, ea1);
            if (lat != 5 || f0 != ef0 || a0 != ea0 || a1 != ea1) bad++;
            if (a0 < 0 || a1 < 0) negs++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL sat_hi_model got=%0d exp=0 (samples off model)", bad); end
        checks++; if (negs !== 0) begin errors++; $display("FAIL sat_hi_negative got=%0d exp=0", negs); end
        checks++; if (a0 !== 511) begin errors++; $display("FAIL sat_hi_angle0 got=%0d exp=511", a0); end
        doReset();
        bad = 0; negs = 0;
        for (int i = 0; i < 200; i++) begin
            runSample(-512, -512, -512, -512, f0, f1, a0, a1, lat);
            modelStep(-512, -512, -512, -512, ef0, ef1, ea0, ea1);
            if (lat != 5 || f1 != ef1 || a0 != ea0 || a1 != ea1) bad++;
            if (a0 > 0 || a1 > 0) negs++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL sat_lo_model got=%0d exp=0 (samples off model)", bad); end
        checks++; if (negs !== 0) begin errors++; $display("FAIL sat_lo_positive got=%0d exp=0", negs); end
        checks++; if (a1 !== -512) begin errors++; $display("FAIL sat_lo_angle1 got=%0d exp=-512", a1); end
    endtask

    task automatic test_reset_mid();
        int f0, f1, a0, a1, lat, pulses;
        doReset();
        runSample(300, 300, 100, 100, f0, f1, a0, a1, lat);
        @(negedge Clock);
        driveData(400, -400, 0, 0);
        bus.DataValid = 1'b1;
        @(posedge Clock);
        #1 bus.DataValid = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        #1;
        checks++; if (bus.FilteredAccel !== '0) begin errors++; $display("FAIL mid_facc got=%h exp=0", bus.FilteredAccel); end
        checks++; if (bus.AngleOut !== '0) begin errors++; $display("FAIL mid_angle got=%h exp=0", bus.AngleOut); end
        checks++; if (bus.AngleValid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", bus.AngleValid); end
        pulses = 0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        modelReset();
        checks++; if (bus.InputReady !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", bus.InputReady); end
        for (int n = 0; n < 8; n++) begin
            @(negedge Clock);
            if (bus.AngleValid) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_pulses got=%0d exp=0", pulses); end
        runSample(200, -200, 0, 0, f0, f1, a0, a1, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL mid_next_latency got=%0d exp=5", lat); end
        checks++; if (f0 !== 25) begin errors++; $display("FAIL mid_next_facc0 got=%0d exp=25", f0); end
        checks++; if (f1 !== -25) begin errors++; $display("FAIL mid_next_facc1 got=%0d exp=-25", f1); end
    endtask

    task automatic test_random();
        int f0, f1, a0, a1, lat, ef0, ef1, ea0, ea1, ra0, ra1, rg0, rg1;
        doReset();
        for (int i = 0; i < 40; i++) begin
            ra0 = int'($urandom_range(1023, 0)) - 512;
            ra1 = int'($urandom_range(1023, 0)) - 512;
            rg0 = int'($urandom_range(1023, 0)) - 512;
            rg1 = int'($urandom_range(1023, 0)) - 512;
            runSample(ra0, ra1, rg0, rg1, f0, f1, a0, a1, lat);
            modelStep(ra0, ra1, rg0, rg1, ef0, ef1, ea0, ea1);
            checks++; if (lat !== 5) begin errors++; $display("FAIL rnd_latency[%0d] got=%0d exp=5", i, lat); end
            checks++; if (f0 !== ef0 || f1 !== ef1) begin errors++; $display("FAIL rnd_facc[%0d] got=%0d,%0d exp=%0d,%0d", i, f0, f1, ef0, ef1); end
            checks++; if (a0 !== ea0 || a1 !== ea1) begin errors++; $display("FAIL rnd_angle[%0d] got=%0d,%0d exp=%0d,%0d", i, a0, a1, ea0, ea1); end
        end
    endtask

    initial begin
        bus.DataValid = 1'b0;
        bus.AccelIn   = '0;
        bus.GyroIn    = '0;
        modelReset();
        test_reset();
        test_ramp();
        test_latency();
        test_overrun();
        test_negative();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
